// File: rtl/filter_word_packer_if.sv
// Handshake and bus bundle between the weight source, the packer and the PE filter FIFO.
// The master side drives weights and FIFO status. The slave side is the packer.
interface filter_word_packer_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int DATA_WIDTH_FILTER = 64,
  parameter int COUNT_WIDTH       = 12
);
  logic                         configure;
  logic [COUNT_WIDTH-1:0]       total_count;
  logic                         in_valid;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         in_ready;
  logic                         push_filter;
  logic [DATA_WIDTH_FILTER-1:0] filter;
  logic                         filter_fifo_full;
  logic                         busy;
  logic                         done;

  modport master (
    output configure, total_count, in_valid, in_data, filter_fifo_full,
    input  in_ready, push_filter, filter, busy, done
  );

  modport slave (
    input  configure, total_count, in_valid, in_data, filter_fifo_full,
    output in_ready, push_filter, filter, busy, done
  );
endinterface

// File: rtl/filter_word_packer.sv
// Packs LANES consecutive 16-bit filter weights into one FIFO word per layer of total_count weights.
// The last partial word is zero-padded. done fires with the final push.
module filter_word_packer #(
  parameter int DATA_WIDTH        = 16,
  parameter int DATA_WIDTH_FILTER = 64,
  parameter int COUNT_WIDTH       = 12
) (
  input  logic                clk,
  input  logic                reset,
  filter_word_packer_if.slave bus
);
  localparam int LANES  = DATA_WIDTH_FILTER / DATA_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_nx;

  logic [COUNT_WIDTH-1:0]           total_q, elem_cnt;
  logic [LANE_W-1:0]                lane;
  logic [LANES-1:0][DATA_WIDTH-1:0] asm_q, asm_nx;
  logic [DATA_WIDTH_FILTER-1:0]     out_reg;
  logic out_pending, zero_done;
  logic last_elem, completing, push_now, accept, cfg_idle;

  assign last_elem  = (elem_cnt == total_q - COUNT_WIDTH'(1));
  assign completing = (lane == LANE_W'(LANES-1)) || last_elem;
  assign push_now   = out_pending && !bus.filter_fifo_full;
  // A completing weight needs the output slot free, or freeing this cycle.
  assign bus.in_ready = (state == FILL) && !(completing && out_pending && !push_now);
  assign accept       = bus.in_valid && bus.in_ready;
  assign cfg_idle     = bus.configure && (state == IDLE);

  assign bus.push_filter = push_now;
  assign bus.filter      = out_reg;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = zero_done || ((state == DRAIN) && push_now);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign asm_nx[g] = (accept && lane == LANE_W'(g)) ? bus.in_data : asm_q[g];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.configure && bus.total_count != '0) state_nx = FILL;
      FILL:    if (accept && last_elem) state_nx = DRAIN;
      DRAIN:   if (push_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      total_q     <= '0;
      elem_cnt    <= '0;
      lane        <= '0;
      asm_q       <= '0;
      out_reg     <= '0;
      out_pending <= 1'b0;
      zero_done   <= 1'b0;
    end else begin
      state     <= state_nx;
      zero_done <= cfg_idle && (bus.total_count == '0);
      if (cfg_idle) begin
        total_q  <= bus.total_count;
        elem_cnt <= '0;
        lane     <= '0;
        asm_q    <= '0;
      end else if (accept) begin
        elem_cnt <= elem_cnt + COUNT_WIDTH'(1);
        if (completing) begin
          lane  <= '0;
          asm_q <= '0;
        end else begin
          lane  <= lane + LANE_W'(1);
          asm_q <= asm_nx;
        end
      end
      // Loading a new word takes priority over clearing pending, so a same-edge push/load keeps it set.
      if (accept && completing) begin
        out_reg     <= asm_nx;
        out_pending <= 1'b1;
      end else if (push_now) begin
        out_pending <= 1'b0;
      end
    end
  end
endmodule
